mem_port_arbiter: RTL and testbench

- Shares the single synchronous memory port between instruction fetch (PC requests) and data access (loads/stores from execute).
- Returns read data to the correct requester after the fixed memory latency.
- Generates stall_pc for the PC/fetch logic when a fetch request is not granted.
- Drops in-flight fetch responses on a branch flush.
- Sits between fetch/execute and the memory, alongside the write-back stage.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single synchronous memory port between instruction fetch and
// execute-stage data accesses, and routes read data back after LOAD_LATENCY.
module mem_port_arbiter #(
  parameter int LOAD_LATENCY = 1,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                fet_req,
  input  logic [ADDR_W-1:0]   fet_addr,
  output logic                fet_gnt,
  input  logic                dat_req,
  input  logic                dat_we,
  input  logic [ADDR_W-1:0]   dat_addr,
  input  logic [DATA_W-1:0]   dat_wdata,
  input  logic [DATA_W/8-1:0] dat_wmask,
  output logic                dat_gnt,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fet_rvalid,
  output logic [DATA_W-1:0]   fet_rdata,
  output logic                dat_rvalid,
  output logic [DATA_W-1:0]   dat_rdata,
  input  logic                flush,
  output logic                stall_pc
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int LAST  = LOAD_LATENCY - 1;

  // Handshake: a request (fet_req/dat_req) with its payload is held stable by
  // the requester until the matching *_gnt is high in the same cycle; the
  // access is transferred on that clock edge. Responses (*_rvalid) carry no
  // ready and cannot be stalled.

  logic [CNT_W-1:0]        starve_cnt;
  logic                    force_fet;
  logic [LOAD_LATENCY-1:0] tag_valid;
  logic [LOAD_LATENCY-1:0] tag_fet;

  assign force_fet = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Data normally wins; a fetch starved for STARVE_LIMIT cycles wins once.
  always_comb begin
    fet_gnt = 1'b0;
    dat_gnt = 1'b0;
    if (rstn) begin
      if (force_fet && fet_req) begin
        fet_gnt = 1'b1;
      end else if (dat_req) begin
        dat_gnt = 1'b1;
      end else begin
        fet_gnt = fet_req;
      end
    end
  end

  always_comb begin
    mem_en    = fet_gnt | dat_gnt;
    mem_we    = dat_gnt & dat_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (dat_gnt) begin
      mem_addr = dat_addr;
    end else if (fet_gnt) begin
      mem_addr = fet_addr;
    end
    if (mem_we) begin
      mem_wdata = dat_wdata;
      mem_wmask = dat_wmask;
    end
  end

  assign stall_pc = fet_req & ~fet_gnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (fet_gnt || !fet_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Flush clears fetch tags as they shift, so a killed fetch simply arrives
  // invalid; the tag already in the last stage still responds this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_valid <= '0;
      tag_fet   <= '0;
    end else begin
      tag_valid[0] <= (fet_gnt | (dat_gnt & ~dat_we)) & ~(flush & fet_gnt);
      tag_fet[0]   <= fet_gnt;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1] & ~(flush & tag_fet[i-1]);
        tag_fet[i]   <= tag_fet[i-1];
      end
    end
  end

  assign fet_rvalid = rstn & tag_valid[LAST] & tag_fet[LAST];
  assign dat_rvalid = rstn & tag_valid[LAST] & ~tag_fet[LAST];
  assign fet_rdata  = fet_rvalid ? mem_rdata : '0;
  assign dat_rdata  = dat_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with LOAD_LATENCY=1 and
// one with LOAD_LATENCY=3, both driven by the same request stream.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fet_req, dat_req, dat_we, flush;
  logic [63:0] fet_addr, dat_addr, dat_wdata, mem_rdata;
  logic [7:0]  dat_wmask;

  logic        fet_gnt, dat_gnt, mem_en, mem_we, fet_rvalid, dat_rvalid, stall_pc;
  logic [63:0] mem_addr, mem_wdata, fet_rdata, dat_rdata;
  logic [7:0]  mem_wmask;

  logic        fet_gnt3, dat_gnt3, mem_en3, mem_we3, fet_rvalid3, dat_rvalid3, stall_pc3;
  logic [63:0] mem_addr3, mem_wdata3, fet_rdata3, dat_rdata3;
  logic [7:0]  mem_wmask3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LOAD_LATENCY(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_gnt(fet_gnt),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
    .dat_wdata(dat_wdata), .dat_wmask(dat_wmask), .dat_gnt(dat_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .fet_rvalid(fet_rvalid), .fet_rdata(fet_rdata),
    .dat_rvalid(dat_rvalid), .dat_rdata(dat_rdata),
    .flush(flush), .stall_pc(stall_pc)
  );

  mem_port_arbiter #(.LOAD_LATENCY(3)) u_dut3 (
    .clk(clk), .rstn(rstn),
    .fet_req(fet_req), .fet_addr(fet_addr), .fet_gnt(fet_gnt3),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr),
    .dat_wdata(dat_wdata), .dat_wmask(dat_wmask), .dat_gnt(dat_gnt3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3), .mem_rdata(mem_rdata),
    .fet_rvalid(fet_rvalid3), .fet_rdata(fet_rdata3),
    .dat_rvalid(dat_rvalid3), .dat_rdata(dat_rdata3),
    .flush(flush), .stall_pc(stall_pc3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("%s differs", tag);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    fet_req = 1'b0;
    dat_req = 1'b0;
    dat_we  = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; idle();
    fet_addr = 64'h0; dat_addr = 64'h0; dat_wdata = 64'hDEAD_BEEF_0000_0001;
    dat_wmask = 8'hFF; mem_rdata = 64'h0;

    // Reset with both requests pending
    next_cycle();
    fet_req = 1'b1; dat_req = 1'b1;
    #1;
    check("rst_fet_gnt", fet_gnt, 0);
    check("rst_dat_gnt", dat_gnt, 0);
    check("rst_mem_en",  mem_en, 0);
    check("rst_mem_we",  mem_we, 0);
    check("rst_fet_rvalid", fet_rvalid, 0);
    check("rst_dat_rvalid", dat_rvalid, 0);
    next_cycle(); rstn = 1'b1; idle(); #1;
    check("idle_mem_en", mem_en, 0);

    // Fetch only, back to back
    next_cycle(); fet_req = 1'b1; fet_addr = 64'h10; #1;
    check("f0_gnt", fet_gnt, 1);
    check("f0_addr", mem_addr, 64'h10);
    check("f0_en", mem_en, 1);
    check("f0_stall", stall_pc, 0);
    check("f0_rvalid", fet_rvalid, 0);
    check("f0_wdata", mem_wdata, 0);
    next_cycle(); fet_addr = 64'h11; mem_rdata = 64'hA0; #1;
    check("f1_gnt", fet_gnt, 1);
    check("f1_addr", mem_addr, 64'h11);
    check("f1_rvalid", fet_rvalid, 1);
    check("f1_rdata", fet_rdata, 64'hA0);
    next_cycle(); fet_addr = 64'h12; mem_rdata = 64'hA1; #1;
    check("f2_addr", mem_addr, 64'h12);
    check("f2_rdata", fet_rdata, 64'hA1);
    check("f2_dat_rvalid", dat_rvalid, 0);
    next_cycle(); idle(); mem_rdata = 64'hA2; #1;
    check("f3_rvalid", fet_rvalid, 1);
    check("f3_rdata", fet_rdata, 64'hA2);
    check("f3_en", mem_en, 0);
    next_cycle(); #1;
    check("f4_rvalid", fet_rvalid, 0);

    // Collision: load beats fetch, fetch granted next cycle
    next_cycle();
    fet_req = 1'b1; fet_addr = 64'h20;
    dat_req = 1'b1; dat_we = 1'b0; dat_addr = 64'h40; #1;
    check("c0_dat_gnt", dat_gnt, 1);
    check("c0_fet_gnt", fet_gnt, 0);
    check("c0_stall", stall_pc, 1);
    check("c0_addr", mem_addr, 64'h40);
    check("c0_we", mem_we, 0);
    check("c0_wdata", mem_wdata, 0);
    check("c0_wmask", mem_wmask, 0);
    next_cycle(); dat_req = 1'b0; mem_rdata = 64'hB0; #1;
    check("c1_dat_rvalid", dat_rvalid, 1);
    check("c1_dat_rdata", dat_rdata, 64'hB0);
    check("c1_fet_rvalid", fet_rvalid, 0);
    check("c1_fet_rdata", fet_rdata, 0);
    check("c1_fet_gnt", fet_gnt, 1);
    check("c1_addr", mem_addr, 64'h20);
    next_cycle(); idle(); mem_rdata = 64'hB1; #1;
    check("c2_fet_rvalid", fet_rvalid, 1);
    check("c2_dat_rvalid", dat_rvalid, 0);

    // Starvation: fetch wins in the 5th and 10th cycles of contention
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      fet_req = 1'b1; fet_addr = 64'h30;
      dat_req = 1'b1; dat_we = 1'b0; dat_addr = 64'h80 + 64'(k);
      mem_rdata = 64'hD000 + 64'(k); #1;
      check($sformatf("s%0d_fet_gnt", k), fet_gnt, (k % 5 == 4) ? 1 : 0);
      check($sformatf("s%0d_dat_gnt", k), dat_gnt, (k % 5 == 4) ? 0 : 1);
      check($sformatf("s%0d_stall", k), stall_pc, (k % 5 == 4) ? 0 : 1);
      check($sformatf("s%0d_addr", k), mem_addr, (k % 5 == 4) ? 64'h30 : 64'h80 + 64'(k));
      check($sformatf("s%0d_dat_rvalid", k), dat_rvalid, (k > 0 && (k - 1) % 5 != 4) ? 1 : 0);
      check($sformatf("s%0d_fet_rvalid", k), fet_rvalid, (k > 0 && (k - 1) % 5 == 4) ? 1 : 0);
    end
    next_cycle(); idle(); #1;
    check("s10_fet_rvalid", fet_rvalid, 1);

    // Store: payload passes through, no read response
    next_cycle();
    dat_req = 1'b1; dat_we = 1'b1; dat_addr = 64'h50;
    dat_wdata = 64'h1122334455667788; dat_wmask = 8'h0F; #1;
    check("st_gnt", dat_gnt, 1);
    check("st_we", mem_we, 1);
    check("st_addr", mem_addr, 64'h50);
    check("st_wdata", mem_wdata, 64'h1122334455667788);
    check("st_wmask", mem_wmask, 8'h0F);
    next_cycle(); idle(); #1;
    check("st_no_rvalid", dat_rvalid, 0);
    check("st_we_off", mem_we, 0);
    next_cycle(); next_cycle(); #1;
    check("drain_fet3", fet_rvalid3, 0);
    check("drain_dat3", dat_rvalid3, 0);

    // Flush with LOAD_LATENCY=3
    next_cycle(); fet_req = 1'b1; fet_addr = 64'h60; #1;
    check("fl0_gnt3", fet_gnt3, 1);
    next_cycle();
    fet_addr = 64'h61; dat_req = 1'b1; dat_we = 1'b0; dat_addr = 64'h70; #1;
    check("fl1_dat_gnt3", dat_gnt3, 1);
    check("fl1_stall3", stall_pc3, 1);
    next_cycle(); dat_req = 1'b0; flush = 1'b1; #1;
    check("fl2_fet_gnt3", fet_gnt3, 1);
    check("fl2_fet_rvalid3", fet_rvalid3, 0);
    next_cycle(); idle(); #1;
    check("fl3_fet_rvalid3", fet_rvalid3, 0);
    next_cycle(); mem_rdata = 64'hE4; #1;
    check("fl4_fet_rvalid3", fet_rvalid3, 0);
    check("fl4_dat_rvalid3", dat_rvalid3, 1);
    check("fl4_dat_rdata3", dat_rdata3, 64'hE4);
    next_cycle(); #1;
    check("fl5_fet_rvalid3", fet_rvalid3, 0);
    check("fl5_dat_rvalid3", dat_rvalid3, 0);

    // A fetch response already due still appears in the flush cycle
    next_cycle(); fet_req = 1'b1; fet_addr = 64'h90;
    next_cycle(); fet_addr = 64'h91;
    next_cycle(); idle();
    next_cycle(); flush = 1'b1; mem_rdata = 64'hE5; #1;
    check("fd_fet_rvalid3", fet_rvalid3, 1);
    check("fd_fet_rdata3", fet_rdata3, 64'hE5);
    next_cycle(); idle(); #1;
    check("fd_killed3", fet_rvalid3, 0);
    next_cycle(); next_cycle();

    // Reset mid-operation: loads in flight, starvation count partly built
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      fet_req = 1'b1; fet_addr = 64'hB0;
      dat_req = 1'b1; dat_we = 1'b0; dat_addr = 64'hA0 + 64'(k);
    end
    next_cycle(); rstn = 1'b0; #1;
    check("mr_mem_en", mem_en, 0);
    check("mr_dat_gnt", dat_gnt, 0);
    check("mr_fet_gnt", fet_gnt, 0);
    check("mr_mem_we", mem_we, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); rstn = 1'b1; #1;
      check($sformatf("pr%0d_dat_gnt", k), dat_gnt, 1);
      check($sformatf("pr%0d_fet_gnt", k), fet_gnt, 0);
      check($sformatf("pr%0d_dat_rvalid3", k), dat_rvalid3, (k == 3) ? 1 : 0);
      check($sformatf("pr%0d_dat_rvalid", k), dat_rvalid, (k == 0) ? 0 : 1);
    end
    next_cycle(); #1;
    check("pr4_fet_gnt", fet_gnt, 1);
    check("pr4_dat_gnt", dat_gnt, 0);
    next_cycle(); idle();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
